// File: rtl/hex_scan_driver.sv
// Time-multiplexed driver for an 8-digit common-anode seven-segment display.
// Optional leading-zero blanking is enabled with `define HEX_SCAN_LZB_EN.
module hex_scan_driver #(
  parameter int DIGITS = 8,
  parameter int DIV    = 50000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] data_i,
  input  logic [7:0]  en_i,
  output logic [6:0]  hex,
  output logic [7:0]  hex_on,
  output logic        frame_o
);
  localparam int CW = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [2:0]    LAST_IDX = 3'(DIGITS - 1);
  localparam logic [CW-1:0] LAST_DIV = CW'(DIV - 1);

  logic [CW-1:0] div_q, div_d;
  logic [2:0]    idx_q, idx_d;
  logic [31:0]   data_sh_q, data_sh_d;
  logic [7:0]    en_sh_q, en_sh_d;
  logic          first_q;
  logic [6:0]    hex_q, hex_d;
  logic [7:0]    hex_on_q, hex_on_d;
  logic          frame_q;

  logic       tick, load, lzb_blank, digit_on;
  logic [3:0] nib;

  assign tick = (div_q == LAST_DIV);
  assign load = (tick && (idx_q == LAST_IDX)) || first_q;

  always_comb begin
    div_d = tick ? '0 : div_q + CW'(1);
    idx_d = idx_q;
    if (tick) idx_d = (idx_q == LAST_IDX) ? 3'd0 : idx_q + 3'd1;
    data_sh_d = load ? data_i : data_sh_q;
    en_sh_d   = load ? en_i   : en_sh_q;
  end

  assign nib = data_sh_q[{idx_q, 2'b00} +: 4];

`ifdef HEX_SCAN_LZB_EN
  // zabove[k]: nibble k and every used nibble above it are zero
  logic [7:0] zabove;
  always_comb begin
    logic acc;
    acc    = 1'b1;
    zabove = '0;
    for (int k = 7; k >= 0; k--) begin
      if (k < DIGITS) acc = acc & (data_sh_q[4*k +: 4] == 4'd0);
      zabove[k] = acc;
    end
  end
  assign lzb_blank = (idx_q != 3'd0) && zabove[idx_q];
`else
  assign lzb_blank = 1'b0;
`endif

  assign digit_on = en_sh_q[idx_q] && !lzb_blank;

  always_comb begin
    hex_on_d = 8'hFF;
    hex_d    = 7'h7F;
    if (digit_on) begin
      hex_on_d = ~(8'd1 << idx_q);
      unique case (nib)
        4'h0: hex_d = 7'h40;
        4'h1: hex_d = 7'h79;
        4'h2: hex_d = 7'h24;
        4'h3: hex_d = 7'h30;
        4'h4: hex_d = 7'h19;
        4'h5: hex_d = 7'h12;
        4'h6: hex_d = 7'h02;
        4'h7: hex_d = 7'h78;
        4'h8: hex_d = 7'h00;
        4'h9: hex_d = 7'h10;
        4'hA: hex_d = 7'h08;
        4'hB: hex_d = 7'h03;
        4'hC: hex_d = 7'h46;
        4'hD: hex_d = 7'h21;
        4'hE: hex_d = 7'h06;
        4'hF: hex_d = 7'h0E;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_q     <= '0;
      idx_q     <= '0;
      data_sh_q <= '0;
      en_sh_q   <= '0;
      first_q   <= 1'b1;
      hex_q     <= 7'h7F;
      hex_on_q  <= 8'hFF;
      frame_q   <= 1'b0;
    end else begin
      div_q     <= div_d;
      idx_q     <= idx_d;
      data_sh_q <= data_sh_d;
      en_sh_q   <= en_sh_d;
      first_q   <= 1'b0;
      hex_q     <= hex_d;
      hex_on_q  <= hex_on_d;
      frame_q   <= load;
    end
  end

  assign hex     = hex_q;
  assign hex_on  = hex_on_q;
  assign frame_o = frame_q;
endmodule

// File: tb/tb_hex_scan_driver.sv
// Directed bench for hex_scan_driver with DIGITS=8, DIV=4.
module tb_hex_scan_driver;
  logic        gclk = 1'b0;
  logic        rst;
  logic [31:0] data_i;
  logic [7:0]  en_i;
  logic [6:0]  hex;
  logic [7:0]  hex_on;
  logic        frame_o;

  hex_scan_driver #(.DIGITS(8), .DIV(4)) dut (
    .clk(gclk), .rst(rst), .data_i(data_i), .en_i(en_i),
    .hex(hex), .hex_on(hex_on), .frame_o(frame_o)
  );

  always #5 gclk = ~gclk;

  logic [6:0] seg_tbl [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                              7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  int nvec = 0, nerr = 0;
  int t;                 // edges since reset release
  logic [31:0] sh_data;  // bench copy of captured word
  logic [7:0]  sh_en;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s t=%0d got=%h exp=%h", tag, t, got, exp);
    end
  endtask

  // Advance n cycles; each expected value uses the capture that precedes the edge.
  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      int d;
      logic on;
      logic [3:0] nb;
      @(posedge gclk); #1;
      t++;
      d  = ((t - 1) / 4) % 8;
      nb = sh_data[4*d +: 4];
      on = sh_en[d];
`ifdef HEX_SCAN_LZB_EN
      if (d != 0 && (sh_data >> (4*d)) == 32'd0) on = 1'b0;
`endif
      chk("hex_on", {24'd0, hex_on}, on ? {24'd0, ~(8'd1 << d)} : 32'hFF);
      chk("hex",    {25'd0, hex},    on ? {25'd0, seg_tbl[nb]} : 32'h7F);
      chk("frame",  {31'd0, frame_o}, (t == 1 || t % 32 == 0) ? 32'd1 : 32'd0);
      if (t == 1 || t % 32 == 0) begin
        sh_data = data_i;
        sh_en   = en_i;
      end
    end
  endtask

  initial begin
    t = 0; sh_data = '0; sh_en = '0;
    rst = 1'b1; data_i = 32'h89ABCDEF; en_i = 8'hFF;
    for (int i = 0; i < 3; i++) begin
      @(posedge gclk); #1;
      chk("rst_hex_on", {24'd0, hex_on}, 32'hFF);
      chk("rst_hex",    {25'd0, hex},    32'h7F);
      chk("rst_frame",  {31'd0, frame_o}, 32'd0);
    end
    rst = 1'b0;
    // full scan, two frames
    step(64);
    // tear-free: zero word captured at edge 96, change to 1s while idx=3
    data_i = 32'h0;
    step(44);
    data_i = 32'h11111111;
    step(52);
    // mask 0x05 takes effect from the frame after the next capture
    en_i = 8'h05;
    step(84);
    // reset while idx=5
    rst = 1'b1;
    @(posedge gclk); #1;
    chk("midrst_hex_on", {24'd0, hex_on}, 32'hFF);
    chk("midrst_hex",    {25'd0, hex},    32'h7F);
    chk("midrst_frame",  {31'd0, frame_o}, 32'd0);
    rst = 1'b0; t = 0; sh_data = '0; sh_en = '0;
    step(40);
`ifdef HEX_SCAN_LZB_EN
    en_i = 8'hFF; data_i = 32'h00000120;
    step(56);
    data_i = 32'h0;
    step(64);
`endif
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
